// File: rtl/vx_dp_ram_sched_pkg.sv
// Shared types and helpers for the dual-port RAM request scheduler.
package vx_dp_ram_sched_pkg;

    // Response index field is sized for up to 256 requesters; callers zero-extend.
    localparam int RSP_IDXW = 8;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic                valid;
        logic [RSP_IDXW-1:0] idx;
    } rsp_pipe_t;

    function automatic int log2up(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_dp_ram_sched_if.sv
// Per-lane request/response bundle between the core lanes and the RAM scheduler.
interface vx_dp_ram_sched_if #(
    parameter int NUM_REQS = 4,
    parameter int DATAW    = 32,
    parameter int ADDRW    = 6
);
    logic [NUM_REQS-1:0]       req_valid;
    logic [NUM_REQS-1:0]       req_rw;
    logic [NUM_REQS*ADDRW-1:0] req_addr;
    logic [NUM_REQS*DATAW-1:0] req_data;
    logic [NUM_REQS-1:0]       req_ready;
    logic [NUM_REQS-1:0]       rsp_valid;
    logic [DATAW-1:0]          rsp_data;
    logic                      init_done;

    modport master (
        output req_valid, req_rw, req_addr, req_data,
        input  req_ready, rsp_valid, rsp_data, init_done
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_data,
        output req_ready, rsp_valid, rsp_data, init_done
    );
endinterface

// File: rtl/VX_dp_ram.sv
// Simple dual-port RAM: one write port with lane enables, one read port with optional output register.
module VX_dp_ram
    import vx_dp_ram_sched_pkg::*;
#(
    parameter int DATAW       = 32,
    parameter int SIZE        = 64,
    parameter int WRENW       = 1,
    parameter int OUT_REG     = 0,
    parameter int NO_RWCHECK  = 0,
    parameter int READ_ENABLE = 0,
    parameter int ADDRW       = log2up(SIZE)
) (
    input  logic             clk,
    input  logic             read,
    input  logic             write,
    input  logic [WRENW-1:0] wren,
    input  logic [ADDRW-1:0] waddr,
    input  logic [DATAW-1:0] wdata,
    input  logic [ADDRW-1:0] raddr,
    output logic [DATAW-1:0] rdata
);
    localparam int LANEW = DATAW / WRENW;

    logic [DATAW-1:0] mem_r [SIZE];
    logic [DATAW-1:0] wmask_s;
    logic [DATAW-1:0] rd_word_s;
    logic             rd_en_s;

    for (genvar g = 0; g < WRENW; g++) begin : g_lane
        assign wmask_s[g*LANEW +: LANEW] = {LANEW{wren[g]}};
    end

    assign rd_en_s = (READ_ENABLE != 0) ? read : 1'b1;

    // Masked word write.
    always_ff @(posedge clk) begin
        if (write) begin
            mem_r[waddr] <= (mem_r[waddr] & ~wmask_s) | (wdata & wmask_s);
        end
    end

    // Read word; without NO_RWCHECK a same-address write is forwarded.
    always_comb begin
        rd_word_s = mem_r[raddr];
        if ((NO_RWCHECK == 0) && write && (waddr == raddr)) begin
            rd_word_s = wdata;
        end else begin
            rd_word_s = mem_r[raddr];
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATAW-1:0] rdata_r;
        // Registered read data.
        always_ff @(posedge clk) begin
            if (rd_en_s) begin
                rdata_r <= rd_word_s;
            end
        end
        assign rdata = rdata_r;
    end else begin : g_out_comb
        assign rdata = rd_word_s;
    end

endmodule

// File: rtl/vx_dp_ram_sched_chk.sv
// Simulation checks for the RAM scheduler: arbitrated addresses must be inside the RAM.
module vx_dp_ram_sched_chk #(
    parameter int ADDRW = 6,
    parameter int SIZE  = 64
) (
    input logic             clk,
    input logic             reset,
    input logic             wr_en,
    input logic [ADDRW-1:0] wr_addr,
    input logic             rd_en,
    input logic [ADDRW-1:0] rd_addr
);
    a_wr_addr_range: assert property (@(posedge clk) disable iff (reset)
        wr_en |-> (int'(wr_addr) < SIZE));

    a_rd_addr_range: assert property (@(posedge clk) disable iff (reset)
        rd_en |-> (int'(rd_addr) < SIZE));
endmodule

// File: rtl/vx_rr_pick.sv
// Round-robin picker: first set mask bit at or after ptr, wrapping modulo N.
module vx_rr_pick
    import vx_dp_ram_sched_pkg::*;
#(
    parameter int N    = 4,
    parameter int SELW = log2up(N)
) (
    input  logic [N-1:0]    mask,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] idx,
    output logic            any
);
    logic [SELW-1:0] cand_s;

    // Scan N positions starting at ptr and keep the first candidate.
    always_comb begin
        idx    = '0;
        any    = 1'b0;
        cand_s = '0;
        for (int i = 0; i < N; i++) begin
            cand_s = SELW'((int'(ptr) + i) % N);
            if (!any && mask[cand_s]) begin
                any = 1'b1;
                idx = cand_s;
            end else begin
                any = any;
            end
        end
        grant = any ? (N'(1'b1) << idx) : '0;
    end

endmodule

// File: rtl/vx_dp_ram_sched.sv
// Shares one write port and one registered read port of a dual-port RAM among NUM_REQS clients,
// after clearing the RAM to INIT_VALUE following reset.
module vx_dp_ram_sched
    import vx_dp_ram_sched_pkg::*;
#(
    parameter int               NUM_REQS   = 4,
    parameter int               DATAW      = 32,
    parameter int               SIZE       = 64,
    parameter logic [DATAW-1:0] INIT_VALUE = '0
) (
    input logic              clk,
    input logic              reset,
    vx_dp_ram_sched_if.slave bus
);
    localparam int ADDRW    = log2up(SIZE);
    localparam int REQ_SELW = log2up(NUM_REQS);

    state_e              state_r, state_s;
    logic [ADDRW-1:0]    init_cnt_r, init_cnt_s;
    logic [REQ_SELW-1:0] wr_ptr_r, wr_ptr_s;
    logic [REQ_SELW-1:0] rd_ptr_r, rd_ptr_s;
    rsp_pipe_t           rsp_pipe_r, rsp_pipe_s;

    logic [ADDRW-1:0]    addr_s [NUM_REQS];
    logic [DATAW-1:0]    data_s [NUM_REQS];
    logic [NUM_REQS-1:0] wr_mask_s, rd_mask_s, wr_grant_s, rd_grant_s;
    logic [REQ_SELW-1:0] wr_idx_s, rd_idx_s;
    logic                wr_any_s, rd_any_s, run_s, hazard_s, rd_fire_s;
    logic [ADDRW-1:0]    wr_addr_s, rd_addr_s;
    logic [DATAW-1:0]    wr_data_s;
    logic                ram_write_s;
    logic [ADDRW-1:0]    ram_waddr_s;
    logic [DATAW-1:0]    ram_wdata_s, ram_rdata_s;

    function automatic logic [REQ_SELW-1:0] ptr_after(input logic [REQ_SELW-1:0] idx);
        if (idx == REQ_SELW'(NUM_REQS - 1)) begin
            return '0;
        end else begin
            return idx + REQ_SELW'(1'b1);
        end
    endfunction

    // Unpack the per-requester address and data lanes.
    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            addr_s[i] = bus.req_addr[i*ADDRW +: ADDRW];
            data_s[i] = bus.req_data[i*DATAW +: DATAW];
        end
    end

    assign run_s     = (state_r == ST_RUN);
    assign wr_mask_s = run_s ? (bus.req_valid & bus.req_rw)  : '0;
    assign rd_mask_s = run_s ? (bus.req_valid & ~bus.req_rw) : '0;

    vx_rr_pick #(.N(NUM_REQS), .SELW(REQ_SELW)) wr_pick (
        .mask  (wr_mask_s),
        .ptr   (wr_ptr_r),
        .grant (wr_grant_s),
        .idx   (wr_idx_s),
        .any   (wr_any_s)
    );

    vx_rr_pick #(.N(NUM_REQS), .SELW(REQ_SELW)) rd_pick (
        .mask  (rd_mask_s),
        .ptr   (rd_ptr_r),
        .grant (rd_grant_s),
        .idx   (rd_idx_s),
        .any   (rd_any_s)
    );

    assign wr_addr_s = addr_s[wr_idx_s];
    assign wr_data_s = data_s[wr_idx_s];
    assign rd_addr_s = addr_s[rd_idx_s];

    // A read colliding with this cycle's write waits so it returns the new data.
    assign hazard_s  = wr_any_s && rd_any_s && (wr_addr_s == rd_addr_s);
    assign rd_fire_s = rd_any_s && !hazard_s;

    // FSM next state: sweep every word once, then serve requests until reset.
    always_comb begin
        state_s    = state_r;
        init_cnt_s = init_cnt_r;
        case (state_r)
            ST_INIT: begin
                init_cnt_s = init_cnt_r + ADDRW'(1'b1);
                if (init_cnt_r == ADDRW'(SIZE - 1)) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_INIT;
                end
            end
            ST_RUN: begin
                state_s = ST_RUN;
            end
            default: begin
                state_s = ST_INIT;
            end
        endcase
    end

    // RAM write port: owned by the init sweep until RUN, then by the write arbiter.
    always_comb begin
        ram_write_s = 1'b0;
        ram_waddr_s = wr_addr_s;
        ram_wdata_s = wr_data_s;
        if (run_s) begin
            ram_write_s = wr_any_s;
        end else begin
            ram_write_s = 1'b1;
            ram_waddr_s = init_cnt_r;
            ram_wdata_s = INIT_VALUE;
        end
    end

    // Pointer advance and response-pipe load.
    always_comb begin
        wr_ptr_s       = wr_any_s ? ptr_after(wr_idx_s) : wr_ptr_r;
        rd_ptr_s       = rd_fire_s ? ptr_after(rd_idx_s) : rd_ptr_r;
        rsp_pipe_s.valid = rd_fire_s;
        rsp_pipe_s.idx   = RSP_IDXW'(rd_idx_s);
    end

    // State, sweep counter, arbitration pointers and response pipe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_INIT;
            init_cnt_r <= '0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            rsp_pipe_r <= '0;
        end else begin
            state_r    <= state_s;
            init_cnt_r <= init_cnt_s;
            wr_ptr_r   <= wr_ptr_s;
            rd_ptr_r   <= rd_ptr_s;
            rsp_pipe_r <= rsp_pipe_s;
        end
    end

    VX_dp_ram #(
        .DATAW       (DATAW),
        .SIZE        (SIZE),
        .WRENW       (1),
        .OUT_REG     (1),
        .NO_RWCHECK  (1),
        .READ_ENABLE (0),
        .ADDRW       (ADDRW)
    ) ram (
        .clk   (clk),
        .read  (rd_fire_s),
        .write (ram_write_s),
        .wren  (1'b1),
        .waddr (ram_waddr_s),
        .wdata (ram_wdata_s),
        .raddr (rd_addr_s),
        .rdata (ram_rdata_s)
    );

    vx_dp_ram_sched_chk #(.ADDRW(ADDRW), .SIZE(SIZE)) chk (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_any_s),
        .wr_addr (wr_addr_s),
        .rd_en   (rd_any_s),
        .rd_addr (rd_addr_s)
    );

    assign bus.req_ready = wr_grant_s | (rd_fire_s ? rd_grant_s : '0);
    assign bus.rsp_valid = rsp_pipe_r.valid ? (NUM_REQS'(1'b1) << rsp_pipe_r.idx) : '0;
    assign bus.rsp_data  = ram_rdata_s;
    assign bus.init_done = run_s;

endmodule

// File: tb/tb_vx_dp_ram_sched.sv
// Directed bench for vx_dp_ram_sched with a per-cycle reference model and hand-computed checks.
module tb_vx_dp_ram_sched;
    localparam int NR = 4;
    localparam int DW = 32;
    localparam int SZ = 64;
    localparam int AW = 6;
    localparam logic [DW-1:0] INITV = 32'h0000_00A5;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   n;

    vx_dp_ram_sched_if #(.NUM_REQS(NR), .DATAW(DW), .ADDRW(AW)) bus ();

    vx_dp_ram_sched #(.NUM_REQS(NR), .DATAW(DW), .SIZE(SZ), .INIT_VALUE(INITV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NR-1:0] oh(input int i);
        logic [NR-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int addr_of(input int i);
        return int'(bus.req_addr[i*AW +: AW]);
    endfunction

    function automatic logic [DW-1:0] data_of(input int i);
        return bus.req_data[i*DW +: DW];
    endfunction

    function automatic int pick(input int ptr, input logic [NR-1:0] mask);
        for (int j = 0; j < NR; j++) begin
            if (mask[(ptr + j) % NR]) return (ptr + j) % NR;
        end
        return -1;
    endfunction

    // Reference model: memory array, pointers and the pending response.
    logic [DW-1:0] m_mem [SZ];
    bit            model_ok = 1'b0;
    bit            m_run = 1'b0;
    int            m_cnt = 0;
    int            m_wr_ptr = 0;
    int            m_rd_ptr = 0;
    bit            m_rsp_v = 1'b0;
    int            m_rsp_idx = 0;
    logic [DW-1:0] m_rsp_data = '0;

    task automatic model_step();
        logic [NR-1:0] wm, rm, exp_rdy, exp_rv;
        int w, r;
        bit rfire;
        exp_rdy = '0;
        w = -1;
        r = -1;
        rfire = 1'b0;
        wm = bus.req_valid & bus.req_rw;
        rm = bus.req_valid & ~bus.req_rw;
        if (m_run) begin
            w = pick(m_wr_ptr, wm);
            r = pick(m_rd_ptr, rm);
            if (w >= 0) exp_rdy[w] = 1'b1;
            if (r >= 0) begin
                rfire = !((w >= 0) && (addr_of(w) == addr_of(r)));
                if (rfire) exp_rdy[r] = 1'b1;
            end
        end
        if (model_ok) begin
            exp_rv = m_rsp_v ? oh(m_rsp_idx) : '0;
            chk("cyc_ready", bus.req_ready, exp_rdy);
            chk("cyc_init_done", bus.init_done, m_run);
            chk("cyc_rsp_valid", bus.rsp_valid, exp_rv);
            if (m_rsp_v) chk("cyc_rsp_data", bus.rsp_data, m_rsp_data);
        end
        if (reset) begin
            model_ok = 1'b1;
            m_run    = 1'b0;
            m_cnt    = 0;
            m_wr_ptr = 0;
            m_rd_ptr = 0;
            m_rsp_v  = 1'b0;
        end else if (!m_run) begin
            m_mem[m_cnt] = INITV;
            if (m_cnt == SZ - 1) m_run = 1'b1;
            m_cnt++;
            m_rsp_v = 1'b0;
        end else begin
            m_rsp_v = rfire;
            if (rfire) begin
                m_rsp_idx  = r;
                m_rsp_data = m_mem[addr_of(r)];
                m_rd_ptr   = (r + 1) % NR;
            end
            if (w >= 0) begin
                m_mem[addr_of(w)] = data_of(w);
                m_wr_ptr = (w + 1) % NR;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            model_step();
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req_valid = '0;
        bus.req_rw    = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
    endtask

    task automatic drive(input int i, input bit rw, input int a, input logic [DW-1:0] d);
        bus.req_valid[i]           = 1'b1;
        bus.req_rw[i]              = rw;
        bus.req_addr[i*AW +: AW]   = AW'(a);
        bus.req_data[i*DW +: DW]   = d;
    endtask

    task automatic do_read(input int i, input int a, input logic [DW-1:0] exp, input string nm);
        idle();
        drive(i, 1'b0, a, '0);
        #1;
        chk({nm, "_ready"}, bus.req_ready, oh(i));
        tick();
        idle();
        chk({nm, "_rsp_valid"}, bus.rsp_valid, oh(i));
        chk({nm, "_rsp_data"}, bus.rsp_data, exp);
    endtask

    task automatic do_write(input int i, input int a, input logic [DW-1:0] d, input string nm);
        idle();
        drive(i, 1'b1, a, d);
        #1;
        chk({nm, "_ready"}, bus.req_ready, oh(i));
        tick();
        idle();
    endtask

    task automatic wait_init(input string nm);
        n = 0;
        while (!bus.init_done && n < 200) begin
            tick();
            n++;
        end
        chk(nm, n, 64);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        repeat (3) tick();
        chk("reset_ready", bus.req_ready, 4'b0000);
        chk("reset_rsp_valid", bus.rsp_valid, 4'b0000);
        chk("reset_init_done", bus.init_done, 1'b0);
        reset = 1'b0;
        wait_init("init_len");

        do_read(0, 0, INITV, "init_rd0");
        do_read(1, 31, INITV, "init_rd31");
        do_read(3, 63, INITV, "init_rd63");

        // All four requesters write at once; grants rotate 0,1,2,3,0.
        idle();
        for (int i = 0; i < NR; i++) drive(i, 1'b1, i, 32'h10 + i);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("wr_rr_grant", bus.req_ready, oh(k % NR));
            tick();
        end
        idle();
        for (int i = 0; i < NR; i++) do_read(i, i, 32'h10 + i, "wr_rr_readback");

        // Back-to-back reads from requester 2.
        do_write(2, 5, 32'h77, "lat_wr");
        drive(2, 1'b0, 5, '0);
        #1;
        chk("b2b_ready0", bus.req_ready, 4'b0100);
        tick();
        chk("b2b_rsp_valid0", bus.rsp_valid, 4'b0100);
        chk("b2b_rsp_data0", bus.rsp_data, 32'h77);
        chk("b2b_ready1", bus.req_ready, 4'b0100);
        tick();
        idle();
        chk("b2b_rsp_valid1", bus.rsp_valid, 4'b0100);
        chk("b2b_rsp_data1", bus.rsp_data, 32'h77);

        // Read hitting the address written in the same cycle is held one cycle.
        idle();
        drive(0, 1'b1, 9, 32'hBEEF);
        drive(1, 1'b0, 9, '0);
        #1;
        chk("haz_ready_w", bus.req_ready, 4'b0001);
        tick();
        bus.req_valid[0] = 1'b0;
        #1;
        chk("haz_ready_r", bus.req_ready, 4'b0010);
        chk("haz_no_rsp", bus.rsp_valid, 4'b0000);
        tick();
        idle();
        chk("haz_rsp_valid", bus.rsp_valid, 4'b0010);
        chk("haz_rsp_data", bus.rsp_data, 32'hBEEF);

        // Independent read and write granted together.
        idle();
        drive(0, 1'b0, 3, '0);
        drive(1, 1'b1, 4, 32'h44);
        #1;
        chk("mix_ready", bus.req_ready, 4'b0011);
        tick();
        idle();
        chk("mix_rsp_valid", bus.rsp_valid, 4'b0001);
        chk("mix_rsp_data", bus.rsp_data, 32'h13);
        do_read(2, 4, 32'h44, "mix_wr_readback");

        // Reset with a read in flight, then again in the middle of the sweep.
        idle();
        drive(2, 1'b0, 5, '0);
        reset = 1'b1;
        #1;
        chk("rst_rd_ready", bus.req_ready, 4'b0100);
        tick();
        idle();
        chk("rst_rsp_dropped", bus.rsp_valid, 4'b0000);
        chk("rst_init_done", bus.init_done, 1'b0);
        tick();
        reset = 1'b0;
        repeat (20) tick();
        chk("sweep20_init_done", bus.init_done, 1'b0);
        reset = 1'b1;
        tick();
        chk("rst2_init_done", bus.init_done, 1'b0);
        chk("rst2_rsp_valid", bus.rsp_valid, 4'b0000);
        reset = 1'b0;
        wait_init("reinit_len");

        do_read(0, 9, INITV, "reinit_rd9");
        do_read(1, 4, INITV, "reinit_rd4");
        do_read(3, 0, INITV, "reinit_rd0");
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
